// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with a valid/ready handshake.
// Carries an opaque payload between CPU pipeline stages. It has two build modes:
//   SKID=0 : single register, in_ready is combinational on out_ready.
//   SKID=1 : main + skid register, in_ready comes straight from a flop.
// Flush turns the stage into a bubble (out_valid=0, out_data=0 acts as a NOP).
// Also tracks the delay-slot flag of the last accepted payload and counts
// back-pressure cycles with a saturating counter.
module pipe_stage_reg #(
   parameter int DATA_W = 160,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_ds_next,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              ds_o,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Saturating increment for the back-pressure counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

   logic              w_accept;
   logic              w_consume;
   logic              w_in_ready;
   logic              w_out_valid;
   logic [DATA_W-1:0] w_main;

   logic              r_ds;
   logic [CNT_W-1:0]  r_stall;

   // Flush wins over any upstream offer; a downstream consume still completes.
   assign w_accept  = in_valid & w_in_ready & ~flush;
   assign w_consume = w_out_valid & out_ready;

   if (SKID == 0) begin : g_single
      logic              r_valid;
      logic              r_init;
      logic [DATA_W-1:0] r_data;

      // Control: occupancy flag and the post-reset ready enable.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_valid <= 1'b0;
            r_init  <= 1'b0;
         end else begin
            r_init <= 1'b1;
            if (flush) begin
               r_valid <= 1'b0;
            end else if (w_accept) begin
               r_valid <= 1'b1;
            end else if (w_consume) begin
               r_valid <= 1'b0;
            end
         end
      end

      // Payload: load on accept, clear to a NOP on flush or drain.
      always_ff @(posedge clk) begin
         if (flush) begin
            r_data <= '0;
         end else if (w_accept) begin
            r_data <= in_data;
         end else if (w_consume) begin
            r_data <= '0;
         end
      end

      // r_init keeps in_ready low until the first edge after reset release.
      assign w_in_ready  = r_init & (~r_valid | out_ready);
      assign w_out_valid = r_valid;
      assign w_main      = r_data;
   end else begin : g_skid
      typedef enum logic [1:0] {
         ST_EMPTY = 2'd0,
         ST_ONE   = 2'd1,
         ST_TWO   = 2'd2
      } state_t;

      state_t            r_state;
      state_t            w_state_nxt;
      logic              r_rdy;
      logic [DATA_W-1:0] r_main;
      logic [DATA_W-1:0] r_skid;
      logic [DATA_W-1:0] w_main_nxt;
      logic [DATA_W-1:0] w_skid_nxt;

      // State register; in_ready is registered from the next state.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_state <= ST_EMPTY;
            r_rdy   <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_rdy   <= (w_state_nxt != ST_TWO);
         end
      end

      // Next state and register moves; skid always holds the younger entry.
      always_comb begin
         w_state_nxt = r_state;
         w_main_nxt  = r_main;
         w_skid_nxt  = r_skid;
         if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = '0;
            w_skid_nxt  = '0;
         end else begin
            case (r_state)
               ST_EMPTY: begin
                  if (w_accept) begin
                     w_state_nxt = ST_ONE;
                     w_main_nxt  = in_data;
                  end
               end
               ST_ONE: begin
                  if (w_accept && w_consume) begin
                     w_main_nxt = in_data;
                  end else if (w_accept) begin
                     w_state_nxt = ST_TWO;
                     w_skid_nxt  = in_data;
                  end else if (w_consume) begin
                     w_state_nxt = ST_EMPTY;
                     w_main_nxt  = '0;
                  end
               end
               ST_TWO: begin
                  // in_ready is low here, so only a drain can happen.
                  if (w_consume) begin
                     w_state_nxt = ST_ONE;
                     w_main_nxt  = r_skid;
                     w_skid_nxt  = '0;
                  end
               end
               default: begin
                  w_state_nxt = ST_EMPTY;
                  w_main_nxt  = '0;
                  w_skid_nxt  = '0;
               end
            endcase
         end
      end

      // Payload registers follow the combinational moves.
      always_ff @(posedge clk) begin
         r_main <= w_main_nxt;
         r_skid <= w_skid_nxt;
      end

      assign w_in_ready  = r_rdy;
      assign w_out_valid = (r_state != ST_EMPTY);
      assign w_main      = r_main;
   end

   // Delay-slot flag of the most recently accepted payload.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ds <= 1'b0;
      end else if (flush) begin
         r_ds <= 1'b0;
      end else if (w_accept) begin
         r_ds <= in_ds_next;
      end
   end

   // Back-pressure counter; survives flush, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall <= '0;
      end else if (w_out_valid && !out_ready) begin
         r_stall <= sat_inc(r_stall);
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   // Gating keeps out_data at zero for bubbles, including during reset.
   assign out_data  = w_out_valid ? w_main : '0;
   assign ds_o      = r_ds;
   assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 instance (index 0) and one SKID=0
// instance (index 1), both 16-bit payload with a 4-bit stall counter.
// Expected payloads go into a per-instance queue when the stimulus issues an
// accepted transfer; a monitor pops and compares on every output handshake.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush      [2];
   logic        in_valid   [2];
   logic        in_ready   [2];
   logic [15:0] in_data    [2];
   logic        in_ds_next [2];
   logic        out_valid  [2];
   logic        out_ready  [2];
   logic [15:0] out_data   [2];
   logic        ds_o       [2];
   logic [3:0]  stall_cnt  [2];

   logic [15:0] q0[$];
   logic [15:0] q1[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(16), .SKID(1), .CNT_W(4)) u_skid (
      .clk(clk), .rst(rst), .flush(flush[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .in_ds_next(in_ds_next[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .ds_o(ds_o[0]), .stall_cnt(stall_cnt[0])
   );

   pipe_stage_reg #(.DATA_W(16), .SKID(0), .CNT_W(4)) u_single (
      .clk(clk), .rst(rst), .flush(flush[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .in_ds_next(in_ds_next[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .ds_o(ds_o[1]), .stall_cnt(stall_cnt[1])
   );

   function automatic string dname(input int d);
      return (d == 0) ? "skid" : "single";
   endfunction

   task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s %s: actual=%0h expected=%0h", dname(d), name, act, exp);
      end
   endtask

   task automatic push(input int d, input logic [15:0] v);
      if (d == 0) q0.push_back(v);
      else        q1.push_back(v);
   endtask

   task automatic clear_q(input int d);
      if (d == 0) q0.delete();
      else        q1.delete();
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic pop_exp(input int d, output logic [15:0] v, output bit ok);
      ok = 1'b0;
      v  = '0;
      if (d == 0 && q0.size() > 0) begin
         v = q0.pop_front(); ok = 1'b1;
      end else if (d == 1 && q1.size() > 0) begin
         v = q1.pop_front(); ok = 1'b1;
      end
   endtask

   task automatic mon_step(input int d);
      logic [15:0] v;
      bit          ok;
      if (out_valid[d] === 1'b1 && out_ready[d] === 1'b1) begin
         pop_exp(d, v, ok);
         if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s unexpected_output: actual=%0h expected=none", dname(d), out_data[d]);
         end else begin
            chk(d, "out_order", out_data[d], v);
         end
      end else if (out_valid[d] !== 1'b1) begin
         chk(d, "idle_zero", out_data[d], 0);
      end
   endtask

   // Monitor: compares every output handshake against the expected queue.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_step(0);
         mon_step(1);
      end
   end

   task automatic set_idle(input int d);
      flush[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0;
      in_ds_next[d] = 1'b0; out_ready[d] = 1'b1;
   endtask

   // One clock cycle of directed stimulus with the hand-computed in_ready.
   task automatic cyc(input int d, input bit iv, input logic [15:0] dat, input bit ds,
                      input bit ordy, input bit fl, input bit exp_rdy);
      in_valid[d] = iv; in_data[d] = dat; in_ds_next[d] = ds;
      out_ready[d] = ordy; flush[d] = fl;
      @(negedge clk);
      chk(d, "in_ready", in_ready[d], exp_rdy);
      @(posedge clk);
      if (iv && exp_rdy && !fl) push(d, dat);
      if (fl) clear_q(d);
      #1;
   endtask

   task automatic do_reset(input int d);
      #1 rst = 1'b0;
      clear_q(0); clear_q(1);
      #1;
      chk(d, "rst_out_valid", out_valid[d], 0);
      chk(d, "rst_out_data", out_data[d], 0);
      chk(d, "rst_ds_o", ds_o[d], 0);
      chk(d, "rst_stall_cnt", stall_cnt[d], 0);
      chk(d, "rst_in_ready", in_ready[d], 0);
      @(posedge clk); @(posedge clk);
      #2 rst = 1'b1;
      #1 chk(d, "rel_in_ready_hold", in_ready[d], 0);
      @(posedge clk); #1;
      chk(d, "rel_in_ready_up", in_ready[d], 1);
   endtask

   task automatic run(input int d);
      bit sk;
      sk = (d == 0);
      set_idle(0); set_idle(1);
      do_reset(d);

      // Stream 1..8 with no back-pressure.
      cyc(d, 1, 16'h1, 0, 1, 0, 1);
      chk(d, "latency_valid", out_valid[d], 1);
      chk(d, "latency_data", out_data[d], 16'h1);
      for (int i = 2; i <= 8; i++) cyc(d, 1, 16'(i), 0, 1, 0, 1);
      cyc(d, 0, 0, 0, 1, 0, 1);
      cyc(d, 0, 0, 0, 1, 0, 1);
      chk(d, "stream_idle_valid", out_valid[d], 0);
      chk(d, "stream_stall_cnt", stall_cnt[d], 0);

      // out_ready low for three cycles in the middle of a stream.
      if (sk) begin
         cyc(d, 1, 16'h11, 0, 1, 0, 1);
         cyc(d, 1, 16'h12, 0, 0, 0, 1);
         cyc(d, 1, 16'h13, 0, 0, 0, 0);
         cyc(d, 1, 16'h13, 0, 0, 0, 0);
         chk(d, "stall_head", out_data[d], 16'h11);
         cyc(d, 1, 16'h13, 0, 1, 0, 0);
         cyc(d, 1, 16'h13, 0, 1, 0, 1);
      end else begin
         cyc(d, 1, 16'h11, 0, 1, 0, 1);
         cyc(d, 1, 16'h12, 0, 0, 0, 0);
         cyc(d, 1, 16'h12, 0, 0, 0, 0);
         cyc(d, 1, 16'h12, 0, 0, 0, 0);
         chk(d, "stall_head", out_data[d], 16'h11);
         cyc(d, 1, 16'h12, 0, 1, 0, 1);
         cyc(d, 1, 16'h13, 0, 1, 0, 1);
      end
      cyc(d, 1, 16'h14, 0, 1, 0, 1);
      cyc(d, 0, 0, 0, 1, 0, 1);
      cyc(d, 0, 0, 0, 1, 0, 1);
      chk(d, "stall_cnt_3", stall_cnt[d], 3);

      // Flush while full, with an offered payload and a completing consume.
      cyc(d, 1, 16'h21, 1, 1, 0, 1);
      cyc(d, 1, 16'h22, 1, 0, 0, sk ? 1'b1 : 1'b0);
      cyc(d, 1, 16'h23, 0, 1, 1, sk ? 1'b0 : 1'b1);
      chk(d, "flush_valid", out_valid[d], 0);
      chk(d, "flush_data", out_data[d], 0);
      chk(d, "flush_ds_o", ds_o[d], 0);
      chk(d, "flush_stall_cnt", stall_cnt[d], 4);
      cyc(d, 0, 0, 0, 1, 0, 1);
      cyc(d, 0, 0, 0, 1, 0, 1);

      // Delay-slot flag holds across idle cycles.
      cyc(d, 1, 16'h31, 1, 1, 0, 1);
      for (int i = 0; i < 5; i++) cyc(d, 0, 0, 0, 1, 0, 1);
      chk(d, "ds_held", ds_o[d], 1);
      cyc(d, 1, 16'h32, 0, 1, 0, 1);
      chk(d, "ds_cleared", ds_o[d], 0);
      cyc(d, 0, 0, 0, 1, 0, 1);
      cyc(d, 0, 0, 0, 1, 0, 1);
      chk(d, "queue_drained", qsize(d), 0);

      // Counter saturation: 19 stalled cycles starting from 4.
      cyc(d, 1, 16'h41, 1, 0, 0, 1);
      for (int i = 0; i < 11; i++) cyc(d, 0, 0, 0, 0, 0, sk);
      chk(d, "stall_at_max", stall_cnt[d], 15);
      for (int i = 0; i < 8; i++) cyc(d, 0, 0, 0, 0, 0, sk);
      chk(d, "stall_saturated", stall_cnt[d], 15);
      chk(d, "sat_held_data", out_data[d], 16'h41);
      chk(d, "sat_ds_o", ds_o[d], 1);

      // Asynchronous reset in the middle of a stalled transfer.
      in_valid[d] = 1'b1; in_data[d] = 16'h42;
      #2 rst = 1'b0;
      #1;
      clear_q(0); clear_q(1);
      in_valid[d] = 1'b0;
      chk(d, "async_out_valid", out_valid[d], 0);
      chk(d, "async_out_data", out_data[d], 0);
      chk(d, "async_ds_o", ds_o[d], 0);
      chk(d, "async_stall_cnt", stall_cnt[d], 0);
      chk(d, "async_in_ready", in_ready[d], 0);
      @(posedge clk); @(posedge clk);
      #2 rst = 1'b1;
      #1 chk(d, "rerel_in_ready_hold", in_ready[d], 0);
      @(posedge clk); #1;
      chk(d, "rerel_in_ready_up", in_ready[d], 1);
      chk(d, "rerel_out_valid", out_valid[d], 0);
      set_idle(d);
   endtask

   initial begin
      set_idle(0); set_idle(1);
      mon_en = 1'b1;
      run(0);
      run(1);
      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
